ahb_slave_mem: RTL and testbench

AHB_SLAVE_MEM -- requirements
Module: ahb_slave_mem

---
 rtl/ahb_slave_mem.sv | 139 +++++++++++++
 tb/tb_ahb_slave_mem.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_mem.sv
// AHB-Lite single-port word memory slave with programmable wait states.
// Optional ERROR responses for illegal transfers: define AHB_SLAVE_ERROR_RESP_EN.
module ahb_slave_mem #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

`ifdef AHB_SLAVE_ERROR_RESP_EN
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;
`else
  typedef enum logic {S_IDLE, S_WAIT} state_t;
`endif

  state_t            state, state_n;
  logic [3:0]        cnt, cnt_n;
  logic              dphase, dphase_n;
  logic [ADDR_W+1:0] addr_r;
  logic              write_r;
  logic [2:0]        size_r;
  logic [31:0]       mem [0:(1<<ADDR_W)-1];

  logic              ready_int;
  logic              accept;
  logic              complete;
  logic [3:0]        lanes;
  logic [ADDR_W-1:0] widx;
  logic              unused_bits;

  assign unused_bits = ^{HADDR[31:ADDR_W+2], HTRANS[0]};
  assign accept      = HSEL && HREADY && HTRANS[1] && ready_int;
  assign complete    = dphase && ready_int;
  assign widx        = addr_r[ADDR_W+1:2];

`ifdef AHB_SLAVE_ERROR_RESP_EN
  logic illegal;
  logic resp_int;
  assign illegal = (HSIZE > 3'd2) || ((HSIZE == 3'd1) && HADDR[0]) ||
                   ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
  assign HRESP   = resp_int;
`else
  assign HRESP   = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    dphase_n  = dphase;
    ready_int = 1'b1;
`ifdef AHB_SLAVE_ERROR_RESP_EN
    resp_int  = 1'b0;
`endif
    case (state)
      S_WAIT: begin
        ready_int = (cnt == '0);
        if (cnt != '0) cnt_n = cnt - 4'd1;
      end
`ifdef AHB_SLAVE_ERROR_RESP_EN
      S_ERR1: begin
        ready_int = 1'b0;
        resp_int  = 1'b1;
        state_n   = S_ERR2;
      end
      S_ERR2: resp_int = 1'b1;
`endif
      default: ;
    endcase
    // Any ready cycle retires the current data phase and may start the next one.
    if (ready_int) begin
      state_n  = S_IDLE;
      dphase_n = 1'b0;
      cnt_n    = '0;
      if (accept) begin
`ifdef AHB_SLAVE_ERROR_RESP_EN
        if (illegal) state_n = S_ERR1;
        else
`endif
        if (WAIT_STATES == 0) begin
          dphase_n = 1'b1;
        end else begin
          state_n  = S_WAIT;
          cnt_n    = 4'(WAIT_STATES);
          dphase_n = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state   <= S_IDLE;
      cnt     <= '0;
      dphase  <= 1'b0;
      addr_r  <= '0;
      write_r <= 1'b0;
      size_r  <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      dphase <= dphase_n;
      if (accept) begin
        addr_r  <= HADDR[ADDR_W+1:0];
        write_r <= HWRITE;
        size_r  <= HSIZE;
      end
    end
  end

  // Lane selection aligns down to the access size; sizes above word act as word.
  always_comb begin
    lanes = 4'b1111;
    if (size_r == 3'd0)      lanes = 4'b0001 << addr_r[1:0];
    else if (size_r == 3'd1) lanes = addr_r[1] ? 4'b1100 : 4'b0011;
  end

  always_ff @(posedge HCLK) begin
    if (complete && write_r) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (lanes[i]) mem[widx][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

  assign HRDATA    = (complete && !write_r) ? mem[widx] : '0;
  assign HREADYOUT = ready_int;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench for ahb_slave_mem: one WAIT_STATES=1 and one WAIT_STATES=0 instance, checked against a memory model.
module tb_ahb_slave_mem;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        dsel;

  logic        hsel_a, hsel_b;
  logic [31:0] rd_a, rd_b, rd_m;
  logic        ro_a, ro_b, ro_m, rs_a, rs_b, rs_m;

  assign hsel_a = hsel && !dsel;
  assign hsel_b = hsel && dsel;
  assign rd_m   = dsel ? rd_b : rd_a;
  assign ro_m   = dsel ? ro_b : ro_a;
  assign rs_m   = dsel ? rs_b : rs_a;

  ahb_slave_mem #(.ADDR_W(8), .WAIT_STATES(1)) dut_a (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel_a), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(ro_a),
    .HRDATA(rd_a), .HREADYOUT(ro_a), .HRESP(rs_a));

  ahb_slave_mem #(.ADDR_W(8), .WAIT_STATES(0)) dut_b (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel_b), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(ro_b),
    .HRDATA(rd_b), .HREADYOUT(ro_b), .HRESP(rs_b));

  int total = 0;
  int bad   = 0;

  logic [31:0] mm [2][256];

  logic [31:0] q_addr[$];
  logic [31:0] q_wd[$];
  logic        q_wr[$];
  logic [2:0]  q_sz[$];
  logic [31:0] o_rd[$];
  int          o_st[$];
  logic        o_rs[$];
  logic [31:0] e_rd[$];
  int          e_st[$];
  logic        e_rs[$];

  function automatic bit is_illegal(input logic [31:0] a, input logic [2:0] s);
`ifdef AHB_SLAVE_ERROR_RESP_EN
    return (s > 3'd2) || ((a % (32'd1 << s)) != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, wd, a, input logic [2:0] s);
    int unsigned nb;
    int unsigned lo;
    logic [31:0] r;
    nb = (s > 3'd2) ? 4 : (1 << s);
    lo = ((a % 4) / nb) * nb;
    r  = old;
    for (int unsigned b = 0; b < 4; b++)
      if (b >= lo && b < lo + nb) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic push(input logic w, input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
    q_wr.push_back(w); q_addr.push_back(a); q_sz.push_back(s); q_wd.push_back(d);
  endtask

  task automatic clear_q();
    q_wr.delete(); q_addr.delete(); q_sz.delete(); q_wd.delete();
    o_rd.delete(); o_st.delete(); o_rs.delete();
    e_rd.delete(); e_st.delete(); e_rs.delete();
  endtask

  task automatic drive_addr(input int k);
    if (k < q_wr.size()) begin
      hsel = 1'b1; htrans = 2'b10; hwrite = q_wr[k]; haddr = q_addr[k]; hsize = q_sz[k];
    end else begin
      hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = $urandom; hsize = 3'd0;
    end
  endtask

  // Expected per-transfer results, applying transfers to the model in bus order.
  task automatic model_seq();
    int d;
    int ws;
    int unsigned idx;
    bit ill;
    d  = dsel ? 1 : 0;
    ws = dsel ? 0 : 1;
    for (int k = 0; k < q_wr.size(); k++) begin
      idx = (q_addr[k] / 4) % 256;
      ill = is_illegal(q_addr[k], q_sz[k]);
      e_rs.push_back(ill);
      e_st.push_back(ill ? 1 : ws);
      e_rd.push_back((ill || q_wr[k]) ? 32'h0 : mm[d][idx]);
      if (q_wr[k] && !ill) mm[d][idx] = merge(mm[d][idx], q_wd[k], q_addr[k], q_sz[k]);
    end
  endtask

  // Pipelined master: next address phase overlaps the current data phase.
  task automatic run_seq();
    int n;
    int ia;
    int id;
    int cyc;
    logic rdy;
    n = q_wr.size(); ia = 0; id = -1; cyc = 0;
    for (int k = 0; k < n; k++) begin
      o_rd.push_back('0); o_st.push_back(0); o_rs.push_back(1'b0);
    end
    @(posedge clk); #1;
    drive_addr(0);
    while (1) begin
      @(negedge clk);
      rdy = ro_m;
      if (id >= 0) begin
        if (rs_m) o_rs[id] = 1'b1;
        if (!rdy) o_st[id] = o_st[id] + 1;
        else      o_rd[id] = rd_m;
      end else if (ia >= n) begin
        break;
      end
      if (cyc >= 20*n + 20) begin
        total++; bad++;
        $display("FAIL seq_timeout cycles=%0d limit=%0d", cyc, 20*n + 20);
        break;
      end
      @(posedge clk); #1;
      cyc++;
      if (rdy) begin
        if (ia < n) begin id = ia; ia++; hwdata = q_wd[id]; end
        else id = -1;
        drive_addr(ia);
      end
    end
    drive_addr(n);
  endtask

  task automatic test_reset();
    rst = 1'b1; dsel = 1'b0; hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
    haddr = '0; hsize = 3'd0; hwdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (ro_a !== 1'b1) begin bad++; $display("FAIL reset_ready_a got=%b req=1", ro_a); end
    total++; if (rs_a !== 1'b0) begin bad++; $display("FAIL reset_resp_a got=%b req=0", rs_a); end
    total++; if (rd_a !== 32'h0) begin bad++; $display("FAIL reset_rdata_a got=%h req=0", rd_a); end
    total++; if (ro_b !== 1'b1) begin bad++; $display("FAIL reset_ready_b got=%b req=1", ro_b); end
    total++; if (rs_b !== 1'b0) begin bad++; $display("FAIL reset_resp_b got=%b req=0", rs_b); end
    total++; if (rd_b !== 32'h0) begin bad++; $display("FAIL reset_rdata_b got=%h req=0", rd_b); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic init_mem();
    for (int d = 0; d < 2; d++) begin
      dsel = (d == 1);
      clear_q();
      for (int i = 0; i < 256; i++) push(1'b1, 32'(i * 4), 3'd2, $urandom);
      model_seq();
      run_seq();
    end
  endtask

  task automatic test_word_and_byte();
    dsel = 1'b0;
    clear_q();
    push(1'b1, 32'h10, 3'd2, 32'hDEADBEEF);
    push(1'b0, 32'h10, 3'd2, $urandom);
    push(1'b1, 32'h10, 3'd2, 32'h11223344);
    push(1'b1, 32'h12, 3'd0, 32'h00AB0000);
    push(1'b0, 32'h10, 3'd2, $urandom);
    model_seq();
    run_seq();
    total++; if (o_st[0] !== 1) begin bad++; $display("FAIL ws1_write_stall got=%0d req=1", o_st[0]); end
    total++; if (o_rd[0] !== 32'h0) begin bad++; $display("FAIL ws1_write_rdata got=%h req=0", o_rd[0]); end
    total++; if (o_st[1] !== 1) begin bad++; $display("FAIL ws1_read_stall got=%0d req=1", o_st[1]); end
    total++; if (o_rd[1] !== 32'hDEADBEEF) begin bad++; $display("FAIL ws1_read_data got=%h req=deadbeef", o_rd[1]); end
    total++; if (o_rs[1] !== 1'b0) begin bad++; $display("FAIL ws1_read_resp got=%b req=0", o_rs[1]); end
    total++; if (o_st[3] !== 1) begin bad++; $display("FAIL byte_write_stall got=%0d req=1", o_st[3]); end
    total++; if (o_rd[4] !== 32'h11AB3344) begin bad++; $display("FAIL byte_merge got=%h req=11ab3344", o_rd[4]); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] w0, w1;
    w0 = $urandom; w1 = $urandom;
    dsel = 1'b1;
    clear_q();
    push(1'b1, 32'h0, 3'd2, w0);
    push(1'b1, 32'h4, 3'd2, w1);
    push(1'b0, 32'h0, 3'd2, $urandom);
    push(1'b0, 32'h4, 3'd2, $urandom);
    model_seq();
    run_seq();
    for (int k = 0; k < 4; k++) begin
      total++; if (o_st[k] !== 0) begin bad++; $display("FAIL ws0_stall[%0d] got=%0d req=0", k, o_st[k]); end
    end
    total++; if (o_rd[2] !== w0) begin bad++; $display("FAIL ws0_read0 got=%h req=%h", o_rd[2], w0); end
    total++; if (o_rd[3] !== w1) begin bad++; $display("FAIL ws0_read4 got=%h req=%h", o_rd[3], w1); end
  endtask

  task automatic test_misaligned();
    logic [31:0] w0, w1, nw;
    dsel = 1'b0;
    w0 = mm[0][0]; w1 = mm[0][1]; nw = $urandom;
    clear_q();
    push(1'b0, 32'h2, 3'd2, $urandom);
    push(1'b1, 32'h6, 3'd2, nw);
    push(1'b0, 32'h4, 3'd2, $urandom);
    model_seq();
    run_seq();
`ifdef AHB_SLAVE_ERROR_RESP_EN
    total++; if (o_rs[0] !== 1'b1) begin bad++; $display("FAIL misalign_resp got=%b req=1", o_rs[0]); end
    total++; if (o_st[0] !== 1) begin bad++; $display("FAIL misalign_err1 got=%0d req=1", o_st[0]); end
    total++; if (o_rd[0] !== 32'h0) begin bad++; $display("FAIL misalign_rdata got=%h req=0", o_rd[0]); end
    total++; if (o_rd[2] !== w1) begin bad++; $display("FAIL misalign_nowrite got=%h req=%h", o_rd[2], w1); end
`else
    total++; if (o_rs[0] !== 1'b0) begin bad++; $display("FAIL misalign_resp got=%b req=0", o_rs[0]); end
    total++; if (o_st[0] !== 1) begin bad++; $display("FAIL misalign_stall got=%0d req=1", o_st[0]); end
    total++; if (o_rd[0] !== w0) begin bad++; $display("FAIL misalign_rdata got=%h req=%h", o_rd[0], w0); end
    total++; if (o_rd[2] !== nw) begin bad++; $display("FAIL misalign_aligned_write got=%h req=%h", o_rd[2], nw); end
`endif
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] prior;
    dsel = 1'b0;
    prior = mm[0][8];
    @(posedge clk); #1;
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h20; hsize = 3'd2;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = 32'h55;
    @(negedge clk);
    total++; if (ro_a !== 1'b0) begin bad++; $display("FAIL midwait_stalled got=%b req=0", ro_a); end
    #1 rst = 1'b1;
    #1;
    total++; if (ro_a !== 1'b1) begin bad++; $display("FAIL abort_ready got=%b req=1", ro_a); end
    total++; if (rs_a !== 1'b0) begin bad++; $display("FAIL abort_resp got=%b req=0", rs_a); end
    total++; if (rd_a !== 32'h0) begin bad++; $display("FAIL abort_rdata got=%h req=0", rd_a); end
    @(posedge clk); #1;
    rst = 1'b0;
    clear_q();
    push(1'b0, 32'h20, 3'd2, $urandom);
    model_seq();
    run_seq();
    total++; if (o_rd[0] !== prior) begin bad++; $display("FAIL abort_nowrite got=%h req=%h", o_rd[0], prior); end
  endtask

  task automatic test_no_select();
    logic [31:0] prior;
    dsel = 1'b0;
    prior = mm[0][12];
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h30; hsize = 3'd2; hwdata = ~prior;
    @(posedge clk); #1;
    hsel = 1'b1; htrans = 2'b01;
    @(negedge clk);
    total++; if (ro_a !== 1'b1) begin bad++; $display("FAIL nosel_ready got=%b req=1", ro_a); end
    total++; if (rs_a !== 1'b0) begin bad++; $display("FAIL nosel_resp got=%b req=0", rs_a); end
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
    @(negedge clk);
    total++; if (ro_a !== 1'b1) begin bad++; $display("FAIL busy_ready got=%b req=1", ro_a); end
    total++; if (rs_a !== 1'b0) begin bad++; $display("FAIL busy_resp got=%b req=0", rs_a); end
    total++; if (rd_a !== 32'h0) begin bad++; $display("FAIL busy_rdata got=%h req=0", rd_a); end
    clear_q();
    push(1'b0, 32'h30, 3'd2, $urandom);
    model_seq();
    run_seq();
    total++; if (o_rd[0] !== prior) begin bad++; $display("FAIL nosel_nowrite got=%h req=%h", o_rd[0], prior); end
  endtask

  task automatic test_random(input logic d);
    logic [31:0] a;
    dsel = d;
    clear_q();
    for (int k = 0; k < 60; k++) begin
      a = $urandom;
      a[9:5] = '0;
      push($urandom_range(0, 1) == 1, a, 3'($urandom_range(0, 4)), $urandom);
    end
    model_seq();
    run_seq();
    for (int k = 0; k < 60; k++) begin
      total++; if (o_rd[k] !== e_rd[k]) begin bad++; $display("FAIL rand%0d_rdata[%0d] got=%h req=%h", d, k, o_rd[k], e_rd[k]); end
      total++; if (o_st[k] !== e_st[k]) begin bad++; $display("FAIL rand%0d_stall[%0d] got=%0d req=%0d", d, k, o_st[k], e_st[k]); end
      total++; if (o_rs[k] !== e_rs[k]) begin bad++; $display("FAIL rand%0d_resp[%0d] got=%b req=%b", d, k, o_rs[k], e_rs[k]); end
    end
  endtask

  initial begin
    test_reset();
    init_mem();
    test_word_and_byte();
    test_zero_wait();
    test_misaligned();
    test_reset_mid_wait();
    test_no_select();
    test_random(1'b0);
    test_random(1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
